// File: rtl/run_controller_if.sv
// Board-side bundle for run_controller: trigger/mode/halt inputs, PC/instruction taps and run status.
// BREAKPOINT_EN adds the bp_addr/bp_valid breakpoint inputs.
interface run_controller_if #(
  parameter int CNT_WIDTH = 32
) ();
  logic                 trigger;
  logic                 step_mode;
  logic                 halt_req;
  logic [31:0]          pc;
  logic [31:0]          instruction;
  logic                 pc_en;
  logic                 running;
  logic                 halted;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] instr_count;
`ifdef BREAKPOINT_EN
  logic [31:0]          bp_addr;
  logic                 bp_valid;
`endif

  modport master (
`ifdef BREAKPOINT_EN
    output bp_addr,
    output bp_valid,
`endif
    output trigger,
    output step_mode,
    output halt_req,
    output pc,
    output instruction,
    input  pc_en,
    input  running,
    input  halted,
    input  state,
    input  instr_count
  );

  modport slave (
`ifdef BREAKPOINT_EN
    input  bp_addr,
    input  bp_valid,
`endif
    input  trigger,
    input  step_mode,
    input  halt_req,
    input  pc,
    input  instruction,
    output pc_en,
    output running,
    output halted,
    output state,
    output instr_count
  );
endinterface

// File: rtl/run_controller.sv
// Run/pause/single-step/halt sequencer for the single-cycle RV32I core; pc_en gates all state updates.
// Optional feature macro: BREAKPOINT_EN (single address breakpoint in RUN).
module run_controller #(
  parameter logic [31:0] HALT_INSTR  = 32'h0000006F,
  parameter int          CNT_WIDTH   = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  run_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t                 r_state;
  logic                   r_running;
  logic                   r_halted;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   r_trig_pulse;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   w_halt_cond;
  logic                   w_bp_hit;
  logic                   w_pc_en;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Trigger synchroniser, then a registered rising-edge pulse (state moves SYNC_STAGES+1 edges after sampling)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync       <= '0;
      r_sync_d     <= 1'b0;
      r_trig_pulse <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], bus.trigger};
      r_sync_d     <= r_sync[SYNC_STAGES-1];
      r_trig_pulse <= r_sync[SYNC_STAGES-1] & ~r_sync_d;
    end
  end

  assign w_halt_cond = bus.halt_req | (bus.instruction == HALT_INSTR);

`ifdef BREAKPOINT_EN
  // bp_skip lets the first RUN cycle after a resume execute the instruction sitting on the breakpoint
  logic r_bp_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bp_skip <= 1'b0;
    else     r_bp_skip <= (r_state == S_IDLE) & r_trig_pulse;
  end

  assign w_bp_hit = (r_state == S_RUN) & bus.bp_valid & (bus.pc == bus.bp_addr) & ~r_bp_skip;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.pc;
  assign w_bp_hit    = 1'b0;
`endif

  assign w_pc_en = ((r_state == S_RUN) | (r_state == S_STEP)) & ~w_halt_cond & ~w_bp_hit;

  // Sequencer; running/halted are registered together with the state they decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_trig_pulse && bus.step_mode) begin
            r_state   <= S_STEP;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
          end else if (r_trig_pulse) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_halt_cond) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else if (w_bp_hit || r_trig_pulse) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
          end
        end
        S_STEP: begin
          if (w_halt_cond) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
          end
        end
        S_HALT: begin
          r_state   <= S_HALT;
          r_running <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_count <= '0;
    else if (w_pc_en) r_count <= sat_inc(r_count);
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.running     = r_running;
  assign bus.halted      = r_halted;
  assign bus.state       = r_state;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_run_controller;

  localparam logic [31:0] HALT = 32'h0000006F;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] r_pc;
  logic [31:0] halt_addr = 32'hFFFF_FFF0;
  int          n_tests = 0;
  int          n_fail  = 0;

  run_controller_if #(.CNT_WIDTH(32)) bus ();

  run_controller #(
    .HALT_INSTR (HALT),
    .CNT_WIDTH  (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Program counter / instruction memory stand-in
  always @(posedge clk or posedge rst) begin
    if (rst)             r_pc <= 32'h0;
    else if (bus.pc_en)  r_pc <= r_pc + 32'd4;
  end
  assign bus.pc          = r_pc;
  assign bus.instruction = (r_pc == halt_addr) ? HALT : NOP;

  typedef struct {
    logic        trig;
    logic        sm;
    logic        hr;
    logic [1:0]  st;
    logic        en;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.trigger   = 1'b0;
    bus.halt_req  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (bus.state == s) break;
      @(negedge clk);
    end
    check(name, {30'd0, bus.state}, {30'd0, s});
  endtask

  initial begin
    int en_cycles;
    int prev_en;
    int back_to_back;

    bus.trigger   = 1'b0;
    bus.step_mode = 1'b0;
    bus.halt_req  = 1'b0;
`ifdef BREAKPOINT_EN
    bus.bp_addr   = 32'h0;
    bus.bp_valid  = 1'b0;
`endif

    //            trig  sm    hr    state  pc_en cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 32'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'd3};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'd3};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'd3};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'd3};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'd3};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'd3};

    // Reset then idle
    do_reset();
    repeat (10) @(negedge clk);
    check("idle state", {30'd0, bus.state}, 32'd0);
    check("idle pc_en", {31'd0, bus.pc_en}, 32'd0);
    check("idle count", bus.instr_count, 32'd0);
    check("idle running", {31'd0, bus.running}, 32'd0);
    check("idle halted", {31'd0, bus.halted}, 32'd0);

    // Per-cycle vector table
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus.trigger   = vecs[i].trig;
      bus.step_mode = vecs[i].sm;
      bus.halt_req  = vecs[i].hr;
      #1;
      check($sformatf("vec%0d state", i), {30'd0, bus.state}, {30'd0, vecs[i].st});
      check($sformatf("vec%0d pc_en", i), {31'd0, bus.pc_en}, {31'd0, vecs[i].en});
      check($sformatf("vec%0d count", i), bus.instr_count, vecs[i].cnt);
    end
    bus.trigger  = 1'b0;
    bus.halt_req = 1'b0;

    // Run into halt instruction at 0x20
    halt_addr     = 32'h20;
    bus.step_mode = 1'b0;
    do_reset();
    pulse_trigger();
    en_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pc_en) en_cycles++;
    end
    check("halt_instr pc_en cycles", en_cycles, 32'd8);
    check("halt_instr state", {30'd0, bus.state}, 32'd3);
    check("halt_instr halted", {31'd0, bus.halted}, 32'd1);
    check("halt_instr running", {31'd0, bus.running}, 32'd0);
    check("halt_instr count", bus.instr_count, 32'd8);
    check("halt_instr pc", bus.pc, 32'h20);
    check("halt_instr pc_en after", {31'd0, bus.pc_en}, 32'd0);
    halt_addr = 32'hFFFF_FFF0;

    // Single-step three times
    bus.step_mode = 1'b1;
    do_reset();
    en_cycles    = 0;
    back_to_back = 0;
    prev_en      = 0;
    for (int p = 0; p < 3; p++) begin
      pulse_trigger();
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        if (bus.pc_en) begin
          en_cycles++;
          if (prev_en != 0) back_to_back++;
        end
        prev_en = int'(bus.pc_en);
      end
      check($sformatf("step%0d idle", p), {30'd0, bus.state}, 32'd0);
    end
    check("step pc_en pulses", en_cycles, 32'd3);
    check("step pulse width", back_to_back, 32'd0);
    check("step count", bus.instr_count, 32'd3);
    check("step pc", bus.pc, 32'hC);

    // Pause / resume, sub-cycle glitch ignored
    bus.step_mode = 1'b0;
    do_reset();
    pulse_trigger();
    wait_state(2'b01, 10, "resume run");
    pulse_trigger();
    wait_state(2'b00, 10, "pause idle");
    check("pause pc_en", {31'd0, bus.pc_en}, 32'd0);
    @(negedge clk);
    #1 bus.trigger = 1'b1;
    #2 bus.trigger = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch ignored", {30'd0, bus.state}, 32'd0);
    pulse_trigger();
    wait_state(2'b01, 10, "second resume");
    check("resumed running", {31'd0, bus.running}, 32'd1);

    // halt_req coincides with trig_pulse in RUN
    @(negedge clk);
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    @(negedge clk);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    #1;
    check("halt_req+trig state", {30'd0, bus.state}, 32'd3);
    check("halt_req+trig pc_en", {31'd0, bus.pc_en}, 32'd0);
    pulse_trigger();
    repeat (6) @(negedge clk);
    check("halt sticky", {30'd0, bus.state}, 32'd3);

    // Asynchronous reset mid-RUN
    do_reset();
    pulse_trigger();
    wait_state(2'b01, 10, "pre-reset run");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst state", {30'd0, bus.state}, 32'd0);
    check("async rst pc_en", {31'd0, bus.pc_en}, 32'd0);
    check("async rst count", bus.instr_count, 32'd0);
    check("async rst running", {31'd0, bus.running}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef BREAKPOINT_EN
    // Breakpoint pause and resume through it
    bus.bp_addr  = 32'h10;
    bus.bp_valid = 1'b1;
    do_reset();
    pulse_trigger();
    wait_state(2'b01, 10, "bp run");
    wait_state(2'b00, 20, "bp pause");
    check("bp pc", bus.pc, 32'h10);
    check("bp count", bus.instr_count, 32'd4);
    pulse_trigger();
    wait_state(2'b01, 10, "bp resume");
    repeat (3) @(negedge clk);
    check("bp no rebreak state", {30'd0, bus.state}, 32'd1);
    check("bp no rebreak pc", bus.pc, 32'h1C);
    bus.bp_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
